assist_seq: RTL and testbench
=============================

ASSIST_SEQ -- requirements
Module: assist_seq

Interface
REQ-001 Parameter: PERIOD, default 1024, auto-trigger interval in clk cycles (legal range 8..65535).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request one assist computation; sampled only in IDLE.
REQ-005 Port: auto_en  input  1  enables the internal periodic trigger.
REQ-006 Port: incline_lim  input  9  unsigned clipped incline factor.
REQ-007 Port: cadence_factor  input  6  unsigned cadence factor.
REQ-008 Port: torque_pos  input  12  unsigned torque above minimum.
REQ-009 Port: scale  input  3  unsigned assist level.
REQ-010 Port: not_pedaling  input  1  forces a zero result.
REQ-011 Port: busy  output  1  high from the cycle after trigger acceptance until done.
REQ-012 Port: done  output  1  one-cycle pulse when target_curr updates.
REQ-013 Port: target_curr  output  12  unsigned motor current target; holds between updates.

Function
REQ-014 Block SHALL compute the assist product using exactly one shared 15x15->30-bit unsigned multiplier, time-multiplexed by an FSM.
REQ-015 FSM states SHALL be IDLE, MUL_A, MUL_B, MUL_C, DONE.
REQ-016 IDLE: trigger = start OR auto_tick; on trigger, capture all operand inputs and not_pedaling into registers and go to MUL_A.
REQ-017 MUL_A SHALL register pa = incline_lim*cadence_factor (15 bits, zero-extended operands); go to MUL_B.
REQ-018 MUL_B SHALL register pb = torque_pos*scale (15 bits); go to MUL_C.
REQ-019 MUL_C SHALL register prod = pa*pb (30 bits); go to DONE.
REQ-020 DONE SHALL assert done for one cycle, load target_curr, and return to IDLE.
REQ-021 Result rule: captured not_pedaling=1 -> 0x000; else prod[29:27]!=0 -> 0xFFF; else prod[26:15].
REQ-022 Latency: trigger sampled at edge N -> done high and target_curr valid after edge N+4; next trigger accepted at edge N+5 at the earliest.
REQ-023 start while not IDLE SHALL be ignored (not queued); input changes after capture SHALL not affect the result.
REQ-024 Auto tick: free-running counter 0..PERIOD-1 counts while auto_en=1, pulses auto_tick on wrap to 0; auto_en=0 clears counter to 0.
REQ-025 auto_tick arriving while busy SHALL be dropped; simultaneous start and auto_tick SHALL produce one computation.
REQ-026 target_curr SHALL change only in DONE.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, busy=0, done=0, target_curr=0x000, counter=0, operand/product registers=0.
REQ-028 Reset mid-computation SHALL abort without a done pulse; first trigger after release behaves as from power-up.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, operand widths (9/6/12/3), product width 30, result slice [26:15] and saturation value 0xFFF.
REQ-030 Multiplier SHALL be a separate sub-module shared_mult (combinational 15x15 unsigned), one instance, operands selected by FSM mux.

Verification
REQ-031 incline_lim=256, cadence_factor=33, torque_pos=1024, scale=7, start pulse -> done 4 cycles later, target_curr=0x738 (1848).
REQ-032 incline_lim=511, cadence_factor=63, torque_pos=4095, scale=7 -> target_curr=0xFFF (saturation).
REQ-033 REQ-031 operands with not_pedaling=1 at start -> target_curr=0x000, done still pulses at +4.
REQ-034 start held high continuously -> done every 5 cycles; start pulses while busy produce no extra done.
REQ-035 auto_en=1, PERIOD=16, start=0 -> done every 16 cycles, first 20 cycles after enable (tick at 16, done at +4); auto_en=0 -> no further done.
REQ-036 rst_n low during MUL_B -> no done, target_curr=0x000; after release, fresh start yields correct result at +4.

Source files
------------

// File: rtl/assist_seq_pkg.sv
// assist_seq_pkg
//   Shared definitions for the assist sequencer: FSM state encoding,
//   operand and product widths, the result slice position and the
//   saturation value, plus the result-selection helper.
package assist_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL_A = 3'd1,
        S_MUL_B = 3'd2,
        S_MUL_C = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int INCLINE_W = 9;
    localparam int CADENCE_W = 6;
    localparam int TORQUE_W  = 12;
    localparam int SCALE_W   = 3;

    // One shared multiplier: both partial products fit in 15 bits.
    localparam int MUL_W  = 15;
    localparam int PROD_W = 30;

    // Result is prod[26:15]; anything set above bit 26 saturates.
    localparam int RES_LSB = 15;
    localparam int RES_MSB = 26;
    localparam int RES_W   = RES_MSB - RES_LSB + 1;

    localparam logic [RES_W-1:0] SAT_VAL = 12'hFFF;

    // prod_hi is prod[29:15]; the low 15 bits never affect the result.
    function automatic logic [RES_W-1:0] assist_result(
        input logic                    not_ped,
        input logic [PROD_W-RES_LSB-1:0] prod_hi
    );
        logic [RES_W-1:0] res;
        if (not_ped) begin
            res = '0;
        end else if (prod_hi[PROD_W-RES_LSB-1:RES_W] != '0) begin
            res = SAT_VAL;
        end else begin
            res = prod_hi[RES_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/assist_seq_shared_mult.sv
// shared_mult
//   Combinational 15x15 -> 30-bit unsigned multiplier shared by all
//   product steps of the assist sequencer.
//   Ports:
//     a, b : 15-bit unsigned operands
//     p    : 30-bit unsigned product
module shared_mult
    import assist_seq_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/assist_seq.sv
// assist_seq
//   Computes a motor current target as
//     (incline_lim*cadence_factor) * (torque_pos*scale), slice [26:15],
//   saturating to 0xFFF and forced to 0 when not pedaling. One shared
//   multiplier is reused over three FSM steps.
//
//   Handshake: a trigger (start, or the internal periodic tick) is taken
//   only on a rising edge where the FSM is IDLE; triggers at any other
//   time are dropped, never queued. done pulses for one cycle on the
//   cycle target_curr takes its new value; target_curr holds otherwise.
//
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     start           : request one computation (sampled in IDLE)
//     auto_en         : enable periodic trigger every PERIOD cycles
//     incline_lim     : 9-bit unsigned operand
//     cadence_factor  : 6-bit unsigned operand
//     torque_pos      : 12-bit unsigned operand
//     scale           : 3-bit unsigned operand
//     not_pedaling    : forces a zero result when captured high
//     busy            : computation in progress
//     done            : one-cycle result strobe
//     target_curr     : 12-bit result, held between updates
module assist_seq
    import assist_seq_pkg::*;
#(
    parameter int PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 auto_en,
    input  logic [INCLINE_W-1:0] incline_lim,
    input  logic [CADENCE_W-1:0] cadence_factor,
    input  logic [TORQUE_W-1:0]  torque_pos,
    input  logic [SCALE_W-1:0]   scale,
    input  logic                 not_pedaling,
    output logic                 busy,
    output logic                 done,
    output logic [RES_W-1:0]     target_curr
);

    localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);

    state_t state;
    state_t state_next;

    logic [15:0]          tick_cnt;
    logic                 auto_tick;
    logic                 trigger;

    logic [INCLINE_W-1:0] cap_incline;
    logic [CADENCE_W-1:0] cap_cadence;
    logic [TORQUE_W-1:0]  cap_torque;
    logic [SCALE_W-1:0]   cap_scale;
    logic                 cap_not_ped;

    logic [MUL_W-1:0]     pa;
    logic [MUL_W-1:0]     pb;
    logic [PROD_W-1:0]    prod;

    logic [MUL_W-1:0]     mul_a;
    logic [MUL_W-1:0]     mul_b;
    logic [PROD_W-1:0]    mul_p;
    logic [RES_W-1:0]     result;

    // Low product bits sit below the result slice and are intentionally
    // discarded.
    logic                 unused_prod_lsbs;
    assign unused_prod_lsbs = ^prod[RES_LSB-1:0];

    // ------------------------------------------------------------------
    // Periodic trigger: counts 0..PERIOD-1 while enabled, ticks on the
    // cycle the counter wraps back to 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!auto_en) begin
            tick_cnt <= '0;
        end else if (tick_cnt == CNT_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    assign auto_tick = auto_en && (tick_cnt == CNT_LAST);
    assign trigger   = start || auto_tick;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (trigger) state_next = S_MUL_A;
            S_MUL_A: state_next = S_MUL_B;
            S_MUL_B: state_next = S_MUL_C;
            S_MUL_C: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Operand mux in front of the single multiplier
    // ------------------------------------------------------------------
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL_A: begin
                mul_a = MUL_W'(cap_incline);
                mul_b = MUL_W'(cap_cadence);
            end
            S_MUL_B: begin
                mul_a = MUL_W'(cap_torque);
                mul_b = MUL_W'(cap_scale);
            end
            S_MUL_C: begin
                mul_a = pa;
                mul_b = pb;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    shared_mult u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    assign result = assist_result(cap_not_ped, prod[PROD_W-1:RES_LSB]);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_incline <= '0;
            cap_cadence <= '0;
            cap_torque  <= '0;
            cap_scale   <= '0;
            cap_not_ped <= 1'b0;
            pa          <= '0;
            pb          <= '0;
            prod        <= '0;
            target_curr <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        cap_incline <= incline_lim;
                        cap_cadence <= cadence_factor;
                        cap_torque  <= torque_pos;
                        cap_scale   <= scale;
                        cap_not_ped <= not_pedaling;
                    end
                end
                // Both partial products are at most 15 bits wide.
                S_MUL_A: pa   <= mul_p[MUL_W-1:0];
                S_MUL_B: pb   <= mul_p[MUL_W-1:0];
                S_MUL_C: prod <= mul_p;
                S_DONE: begin
                    target_curr <= result;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_assist_seq.sv
module tb_assist_seq;

  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic [8:0]  incline_lim = '0;
  logic [5:0]  cadence_factor = '0;
  logic [11:0] torque_pos = '0;
  logic [2:0]  scale = '0;
  logic        not_pedaling = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] target_curr;

  assist_seq #(.PERIOD(PERIOD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .auto_en        (auto_en),
    .incline_lim    (incline_lim),
    .cadence_factor (cadence_factor),
    .torque_pos     (torque_pos),
    .scale          (scale),
    .not_pedaling   (not_pedaling),
    .busy           (busy),
    .done           (done),
    .target_curr    (target_curr)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state (edge-indexed)
  int          edge_no = 0;
  int          m_cnt = 0;
  int          m_free_at = 0;
  int          m_done_at = -100;
  logic [11:0] m_target = '0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_result(input bit np, input int inc, input int cad,
                                             input int tq, input int sc);
    longint p;
    if (np) return 12'h000;
    p = longint'(inc * cad) * longint'(tq * sc);
    if (p >= (longint'(1) << 27)) return 12'hFFF;
    return 12'(p >> 15);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_free_at = 0;
    m_done_at = -100;
    m_target = '0;
    exp_q.delete();
  endtask

  // Applies the rules for the upcoming rising edge using current inputs.
  task automatic model_edge();
    bit tick;
    edge_no++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = auto_en && (m_cnt == PERIOD - 1);
    if (!auto_en) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % PERIOD;
    if (edge_no >= m_free_at && (start || tick)) begin
      exp_q.push_back(ref_result(not_pedaling, int'(incline_lim), int'(cadence_factor),
                                 int'(torque_pos), int'(scale)));
      m_done_at = edge_no + 4;
      m_free_at = edge_no + 5;
    end
    if (edge_no == m_done_at) m_target = exp_q.pop_front();
  endtask

  task automatic step();
    bit exp_done;
    bit exp_busy;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    exp_done = (edge_no == m_done_at);
    exp_busy = (edge_no >= m_done_at - 4) && (edge_no < m_done_at);
    check("done", 32'(done), 32'(exp_done));
    check("busy", 32'(busy), 32'(exp_busy));
    check("target_curr", 32'(target_curr), 32'(m_target));
  endtask

  task automatic set_ops(input int inc, input int cad, input int tq, input int sc, input bit np);
    incline_lim    = 9'(inc);
    cadence_factor = 6'(cad);
    torque_pos     = 12'(tq);
    scale          = 3'(sc);
    not_pedaling   = np;
  endtask

  task automatic rand_ops();
    if ($urandom_range(0, 3) == 0) begin
      set_ops($urandom_range(400, 511), $urandom_range(40, 63),
              $urandom_range(3000, 4095), $urandom_range(5, 7), 1'b0);
    end else begin
      set_ops($urandom_range(0, 511), $urandom_range(0, 63),
              $urandom_range(0, 4095), $urandom_range(0, 7), 1'b0);
    end
    not_pedaling = ($urandom_range(0, 7) == 0);
  endtask

  // asserts reset asynchronously in the low clock phase
  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_target", 32'(target_curr), 32'd0);
  endtask

  int n_done;
  int first_done;

  initial begin
    // reset
    #1;
    model_reset();
    check("por_busy", 32'(busy), 32'd0);
    check("por_done", 32'(done), 32'd0);
    check("por_target", 32'(target_curr), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // nominal computation; operands change after capture
    set_ops(256, 33, 1024, 7, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    rand_ops();
    for (int i = 0; i < 4; i++) step();
    check("nominal_done", 32'(done), 32'd1);
    check("nominal_value", 32'(target_curr), 32'h738);
    step();
    check("nominal_hold", 32'(target_curr), 32'h738);

    // saturation, with start pulses while busy ignored
    set_ops(511, 63, 4095, 7, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    step();
    check("sat_done", 32'(done), 32'd1);
    check("sat_value", 32'(target_curr), 32'hFFF);

    // not pedaling forces zero
    set_ops(256, 33, 1024, 7, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("np_done", 32'(done), 32'd1);
    check("np_value", 32'(target_curr), 32'h000);

    // start held high: one result every 5 cycles
    set_ops(300, 20, 2000, 3, 1'b0);
    start = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) n_done++;
    end
    start = 1'b0;
    check("held_start_count", 32'(n_done), 32'd4);
    step();

    // periodic trigger
    auto_en = 1'b0;
    step();
    auto_en = 1'b1;
    n_done = 0;
    first_done = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
    end
    check("auto_first_done", 32'(first_done), 32'd20);
    check("auto_count", 32'(n_done), 32'd3);
    auto_en = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) n_done++;
    end
    check("auto_off_count", 32'(n_done), 32'd0);

    // reset during MUL_B aborts, then a fresh start works
    set_ops(256, 33, 1024, 7, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    assert_reset();
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) n_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_target", 32'(target_curr), 32'h000);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("post_reset_done", 32'(done), 32'd1);
    check("post_reset_value", 32'(target_curr), 32'h738);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      rand_ops();
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end
    start = 1'b0;
    auto_en = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
